fir_ss_feeder: RTL and testbench

FIR_SS_FEEDER -- requirements
Module: fir_ss_feeder

---
 rtl/fir_ss_feeder_if.sv | 23 ++
 rtl/fir_ss_feeder.sv | 131 +++++++++++++
 tb/tb_fir_ss_feeder.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/fir_ss_feeder_if.sv
// rtl/fir_ss_feeder_if.sv - upstream and FIR ss stream signals of the feeder
interface fir_ss_feeder_if #(
    parameter int pDATA_WIDTH = 32
);
    logic                   in_tvalid;
    logic                   in_tready;
    logic [pDATA_WIDTH-1:0] in_tdata;
    logic                   ss_tvalid;
    logic                   ss_tready;
    logic [pDATA_WIDTH-1:0] ss_tdata;
    logic                   ss_tlast;

    // master: the feeder itself; slave: the bridge/FIR environment around it
    modport master (
        input  in_tvalid, in_tdata, ss_tready,
        output in_tready, ss_tvalid, ss_tdata, ss_tlast
    );

    modport slave (
        output in_tvalid, in_tdata, ss_tready,
        input  in_tready, ss_tvalid, ss_tdata, ss_tlast
    );
endinterface

// File: rtl/fir_ss_feeder.sv
// rtl/fir_ss_feeder.sv - frame-length-limited FWFT FIFO feeding the FIR ss stream
// Optional occupancy output fifo_level enabled by FIR_SS_FEEDER_LEVEL_EN.
module fir_ss_feeder #(
    parameter int pDATA_WIDTH = 32,
    parameter int pDEPTH      = 8,
    parameter int pLEN_WIDTH  = 32
) (
    input  logic                  axis_clk,
    input  logic                  axis_rst_n,
    input  logic                  start,
    input  logic [pLEN_WIDTH-1:0] data_length,
    fir_ss_feeder_if.master       strm,
    output logic                  busy,
`ifdef FIR_SS_FEEDER_LEVEL_EN
    output logic [$clog2(pDEPTH):0] fifo_level,
`endif
    output logic                  done
);
    localparam int AW = $clog2(pDEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                 state_q, state_d;
    logic [pLEN_WIDTH-1:0]  len_q, len_d;
    logic [pLEN_WIDTH-1:0]  acc_cnt_q, acc_cnt_d;
    logic [pLEN_WIDTH-1:0]  sent_cnt_q, sent_cnt_d;
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]          count_q, count_d;
    logic [pDATA_WIDTH-1:0] mem_q [pDEPTH];

    logic fifo_full;
    logic fifo_empty;
    logic in_ready;
    logic last_beat;
    logic push;
    logic pop;

    assign fifo_full  = (count_q == CW'(pDEPTH));
    assign fifo_empty = (count_q == '0);
    // Ready comes only from registered state so ss_tready never reaches in_tready.
    assign in_ready   = (state_q == S_RUN) && !fifo_full && (acc_cnt_q < len_q);
    assign last_beat  = (sent_cnt_q == len_q - pLEN_WIDTH'(1));
    assign push       = strm.in_tvalid && in_ready;
    assign pop        = !fifo_empty && strm.ss_tready;

    assign strm.in_tready = in_ready;
    assign strm.ss_tvalid = !fifo_empty;
    assign strm.ss_tdata  = fifo_empty ? '0 : mem_q[rd_ptr_q];
    assign strm.ss_tlast  = !fifo_empty && last_beat;
    assign busy           = (state_q == S_RUN);
    assign done           = (state_q == S_DONE);

`ifdef FIR_SS_FEEDER_LEVEL_EN
    assign fifo_level = count_q;
`endif

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        acc_cnt_d  = acc_cnt_q;
        sent_cnt_d = sent_cnt_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    if (data_length != '0) begin
                        state_d    = S_RUN;
                        len_d      = data_length;
                        acc_cnt_d  = '0;
                        sent_cnt_d = '0;
                        wr_ptr_d   = '0;
                        rd_ptr_d   = '0;
                        count_d    = '0;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_RUN: begin
                if (push) begin
                    acc_cnt_d = acc_cnt_q + pLEN_WIDTH'(1);
                    wr_ptr_d  = wr_ptr_q + AW'(1);
                end
                if (pop) begin
                    sent_cnt_d = sent_cnt_q + pLEN_WIDTH'(1);
                    rd_ptr_d   = rd_ptr_q + AW'(1);
                    if (last_beat) begin
                        state_d = S_DONE;
                    end
                end
                case ({push, pop})
                    2'b10:   count_d = count_q + CW'(1);
                    2'b01:   count_d = count_q - CW'(1);
                    default: count_d = count_q;
                endcase
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            acc_cnt_q  <= '0;
            sent_cnt_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            acc_cnt_q  <= acc_cnt_d;
            sent_cnt_q <= sent_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Storage is left unreset; the empty-gated ss_tdata mux hides stale entries.
    always_ff @(posedge axis_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= strm.in_tdata;
        end
    end
endmodule

// File: tb/tb_fir_ss_feeder.sv
// tb/tb_fir_ss_feeder.sv - directed self-checking bench for fir_ss_feeder
module tb_fir_ss_feeder;
    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int LW    = 32;

    logic          axis_clk;
    logic          axis_rst_n;
    logic          start;
    logic [LW-1:0] data_length;
    logic          busy;
    logic          done;
`ifdef FIR_SS_FEEDER_LEVEL_EN
    logic [3:0]    fifo_level;
`endif

    int vectors     = 0;
    int miscompares = 0;

    fir_ss_feeder_if #(.pDATA_WIDTH(DW)) strm ();

    fir_ss_feeder #(
        .pDATA_WIDTH(DW),
        .pDEPTH     (DEPTH),
        .pLEN_WIDTH (LW)
    ) dut (
        .axis_clk   (axis_clk),
        .axis_rst_n (axis_rst_n),
        .start      (start),
        .data_length(data_length),
        .strm       (strm.master),
        .busy       (busy),
`ifdef FIR_SS_FEEDER_LEVEL_EN
        .fifo_level (fifo_level),
`endif
        .done       (done)
    );

    initial begin
        axis_clk = 1'b0;
        forever #5 axis_clk = ~axis_clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge axis_clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_tready"}, strm.in_tready, 0);
        chk({tag, "_ss_tvalid"}, strm.ss_tvalid, 0);
        chk({tag, "_ss_tlast"},  strm.ss_tlast, 0);
        chk({tag, "_ss_tdata"},  strm.ss_tdata, 0);
        chk({tag, "_busy"},      busy, 0);
        chk({tag, "_done"},      done, 0);
    endtask

    // Upstream offers 'offer' samples base, base+1, ...; ss_tready held low for 'stall' cycles.
    task automatic run_frame(input int len, input int offer, input int stall, input bit rnd,
                             input logic [31:0] base);
        int acc;
        int sent;
        int occ;
        int cyc;
        bit push;
        bit pop;
        start       = 1'b1;
        data_length = LW'(len);
        step();
        start       = 1'b0;
        data_length = '1;
        chk("busy_after_start", busy, 1);
        acc  = 0;
        sent = 0;
        occ  = 0;
        cyc  = 0;
        while (sent < len && cyc < 3000) begin
            strm.in_tvalid = (acc < offer) && (!rnd || $urandom_range(0, 1) == 1);
            strm.in_tdata  = base + 32'(acc);
            strm.ss_tready = (cyc >= stall) && (!rnd || $urandom_range(0, 3) != 0);
            // a start pulse mid-frame must not disturb the running frame
            start          = (stall > 0) && (cyc == 3);
            data_length    = start ? LW'(1) : '1;
            @(negedge axis_clk);
            chk("in_tready", strm.in_tready, (acc < len) && (occ < DEPTH));
            chk("ss_tvalid", strm.ss_tvalid, occ != 0);
            chk("busy_run",  busy, 1);
            if (occ != 0) begin
                chk("ss_tdata", strm.ss_tdata, base + 32'(sent));
                chk("ss_tlast", strm.ss_tlast, sent == len - 1);
            end
`ifdef FIR_SS_FEEDER_LEVEL_EN
            chk("fifo_level", fifo_level, occ);
`endif
            push = strm.in_tvalid && strm.in_tready;
            pop  = strm.ss_tvalid && strm.ss_tready;
            step();
            acc  += int'(push);
            sent += int'(pop);
            occ  += int'(push) - int'(pop);
            cyc++;
        end
        start          = 1'b0;
        strm.in_tvalid = 1'b0;
        strm.ss_tready = 1'b0;
        chk("frame_beats_sent", sent, len);
        chk("frame_beats_accepted", acc, len);
        chk("frame_done", done, 1);
        chk("frame_busy", busy, 0);
        chk("frame_ss_tvalid", strm.ss_tvalid, 0);
    endtask

    initial begin
        axis_rst_n     = 1'b0;
        start          = 1'b0;
        data_length    = '0;
        strm.in_tvalid = 1'b0;
        strm.in_tdata  = '0;
        strm.ss_tready = 1'b0;
        repeat (3) step();
        chk_reset_outputs("reset");
        axis_rst_n = 1'b1;
        step();
        chk_reset_outputs("idle");

        // basic 4-sample frame, tlast only on 0x14
        run_frame(4, 4, 0, 1'b0, 32'h11);
        repeat (3) step();
        chk("done_holds", done, 1);

        // 10 samples into 8 entries with downstream stalled, then drained
        run_frame(10, 10, 9, 1'b0, 32'h100);

        // upstream offers 5, only 3 may be accepted
        run_frame(3, 5, 0, 1'b0, 32'h30);

        // zero-length frame goes straight to DONE without any ss beat
        start       = 1'b1;
        data_length = '0;
        step();
        start = 1'b0;
        chk("zero_done", done, 1);
        chk("zero_busy", busy, 0);
        chk("zero_in_tready", strm.in_tready, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("zero_ss_tvalid", strm.ss_tvalid, 0);
            chk("zero_done_hold", done, 1);
        end

        // long frame with random valid and back-pressure
        run_frame(100, 100, 0, 1'b1, 32'h1000);

        // reset after 2 of 6 samples aborts the frame
        start       = 1'b1;
        data_length = 6;
        step();
        start          = 1'b0;
        strm.ss_tready = 1'b0;
        strm.in_tvalid = 1'b1;
        strm.in_tdata  = 32'h51;
        step();
        strm.in_tdata  = 32'h52;
        step();
        strm.in_tvalid = 1'b0;
        @(negedge axis_clk);
        chk("pre_rst_ss_tvalid", strm.ss_tvalid, 1);
        chk("pre_rst_ss_tdata", strm.ss_tdata, 32'h51);
        #2 axis_rst_n = 1'b0;
        #1 chk_reset_outputs("async_rst");
        step();
        axis_rst_n = 1'b1;
        strm.ss_tready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_reset_outputs("post_rst");
        end
        strm.ss_tready = 1'b0;
        run_frame(2, 2, 0, 1'b0, 32'hA0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
